// File: rtl/bin2dec_pkg.sv
// Shared types and digit-code helpers for the binary-to-decimal display formatter.
package bin2dec_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FMT   = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Digit code layout: {blank, dp, dash, value[3:0]}
   localparam int BLANK_BIT  = 6;
   localparam int DP_BIT     = 5;
   localparam int DASH_BIT   = 4;
   localparam int BCD_DIGITS = 7;

   localparam logic [6:0] DIGIT_BLANK = 7'b100_0000;

   function automatic logic [6:0] mk_digit(input logic       blank,
                                           input logic       dp,
                                           input logic       dash,
                                           input logic [3:0] val);
      logic [6:0] code;
      code           = {3'b000, val};
      code[BLANK_BIT] = blank;
      code[DP_BIT]    = dp;
      code[DASH_BIT]  = dash;
      return code;
   endfunction

endpackage

// File: rtl/bin2dec_disp_bcd_add3.sv
// Double-dabble nibble correction: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
   input  logic [3:0] nib,
   output logic [3:0] adj
);

   assign adj = (nib >= 4'd5) ? (nib + 4'd3) : nib;

endmodule

// File: rtl/bin2dec_disp.sv
// Signed binary to 8-digit seven-segment code formatter. Sequential
// double-dabble (one bit per clock), then leading-zero blanking, optional
// decimal point and minus sign. Digit outputs only change on entry to DONE.
module bin2dec_disp
   import bin2dec_pkg::*;
#(
   parameter int W  = 24,
   parameter int ND = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] value,
   input  logic         dp_en,
   input  logic [2:0]   dp_pos,
   output logic         busy,
   output logic         done,
   output logic [6:0]   d7,
   output logic [6:0]   d6,
   output logic [6:0]   d5,
   output logic [6:0]   d4,
   output logic [6:0]   d3,
   output logic [6:0]   d2,
   output logic [6:0]   d1,
   output logic [6:0]   d0
);

   localparam int CW = $clog2(W + 1);
   localparam int BW = 4 * BCD_DIGITS;

   state_t           state_r;
   state_t           state_nxt_s;
   logic             busy_r;
   logic             done_r;
   logic             busy_nxt_s;
   logic             done_nxt_s;
   logic             neg_r;
   logic             dp_en_r;
   logic [2:0]       dp_pos_r;
   logic [2:0]       dp_pos_clamp_s;
   logic [W-1:0]     mag_r;
   logic [W-1:0]     mag_in_s;
   logic [CW-1:0]    cnt_r;
   logic [BW-1:0]    bcd_r;
   logic [BW-1:0]    bcd_adj_s;
   logic [4*ND-1:0]  bcd_pad_s;
   logic [2:0]       msd_s;
   logic [2:0]       top_s;
   logic [6:0]       digit_r [ND];
   logic [6:0]       fmt_s   [ND];

   // Per-digit add-3 correction ahead of each shift
   genvar g;
   generate
      for (g = 0; g < BCD_DIGITS; g++) begin : g_add3
         bcd_add3 u_add3 (
            .nib (bcd_r[4*g +: 4]),
            .adj (bcd_adj_s[4*g +: 4])
         );
      end
   endgenerate

   // Magnitude of the incoming value; -2^(W-1) maps exactly onto 2^(W-1)
   always_comb begin
      if (value[W-1]) begin
         mag_in_s = (~value) + W'(1);
      end else begin
         mag_in_s = value;
      end
   end

   // Decimal-point positions beyond the 7 value digits collapse onto digit 6
   always_comb begin
      if (dp_pos > 3'd6) begin
         dp_pos_clamp_s = 3'd6;
      end else begin
         dp_pos_clamp_s = dp_pos;
      end
   end

   // State register plus registered busy/done flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= busy_nxt_s;
         done_r  <= done_nxt_s;
      end
   end

   // Next-state logic; start is only honoured in IDLE
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = SHIFT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_r == CW'(1)) begin
               state_nxt_s = FMT;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         FMT:     state_nxt_s = DONE;
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Flags for the state being entered, so busy/done come straight from flops
   always_comb begin
      busy_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
      case (state_nxt_s)
         SHIFT:   busy_nxt_s = 1'b1;
         FMT:     busy_nxt_s = 1'b1;
         DONE:    done_nxt_s = 1'b1;
         default: busy_nxt_s = 1'b0;
      endcase
   end

   // Conversion datapath: latch on start, shift during SHIFT, publish on FMT->DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_r    <= 1'b0;
         dp_en_r  <= 1'b0;
         dp_pos_r <= 3'd0;
         mag_r    <= {W{1'b0}};
         cnt_r    <= {CW{1'b0}};
         bcd_r    <= {BW{1'b0}};
         for (int i = 0; i < ND; i++) begin
            digit_r[i] <= DIGIT_BLANK;
         end
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  neg_r    <= value[W-1];
                  mag_r    <= mag_in_s;
                  dp_en_r  <= dp_en;
                  dp_pos_r <= dp_pos_clamp_s;
                  bcd_r    <= {BW{1'b0}};
                  cnt_r    <= CW'(W);
               end
            end
            SHIFT: begin
               bcd_r <= {bcd_adj_s[BW-2:0], mag_r[W-1]};
               mag_r <= {mag_r[W-2:0], 1'b0};
               cnt_r <= cnt_r - CW'(1);
            end
            FMT: begin
               for (int i = 0; i < ND; i++) begin
                  digit_r[i] <= fmt_s[i];
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign bcd_pad_s = {{(4*ND-BW){1'b0}}, bcd_r};

   // Most significant nonzero digit and the highest digit that must be lit
   always_comb begin
      msd_s = 3'd0;
      for (int i = 1; i < BCD_DIGITS; i++) begin
         if (bcd_r[4*i +: 4] != 4'd0) begin
            msd_s = 3'(i);
         end else begin
            msd_s = msd_s;
         end
      end
      if (dp_en_r && (dp_pos_r > msd_s)) begin
         top_s = dp_pos_r;
      end else begin
         top_s = msd_s;
      end
   end

   // Digit codes: lit up to top, minus sign just above it, blank beyond
   always_comb begin
      for (int i = 0; i < ND; i++) begin
         if (i <= int'(top_s)) begin
            fmt_s[i] = mk_digit(1'b0, dp_en_r && (i == int'(dp_pos_r)), 1'b0,
                                bcd_pad_s[4*i +: 4]);
         end else if (neg_r && (i == int'(top_s) + 1)) begin
            fmt_s[i] = mk_digit(1'b0, 1'b0, 1'b1, 4'd0);
         end else begin
            fmt_s[i] = DIGIT_BLANK;
         end
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign d0   = digit_r[0];
   assign d1   = digit_r[1];
   assign d2   = digit_r[2];
   assign d3   = digit_r[3];
   assign d4   = digit_r[4];
   assign d5   = digit_r[5];
   assign d6   = digit_r[6];
   assign d7   = digit_r[7];

endmodule

// File: tb/tb_bin2dec_disp.sv
// Directed self-checking bench for bin2dec_disp.
module tb_bin2dec_disp;

   localparam int W = 24;
   localparam logic [55:0] ALL_BLANK = {8{7'h40}};

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] value;
   logic         dp_en;
   logic [2:0]   dp_pos;
   logic         busy;
   logic         done;
   logic [6:0]   d7, d6, d5, d4, d3, d2, d1, d0;
   logic [55:0]  disp;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign disp = {d7, d6, d5, d4, d3, d2, d1, d0};

   bin2dec_disp #(.W(W), .ND(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .value  (value),
      .dp_en  (dp_en),
      .dp_pos (dp_pos),
      .busy   (busy),
      .done   (done),
      .d7     (d7),
      .d6     (d6),
      .d5     (d5),
      .d4     (d4),
      .d3     (d3),
      .d2     (d2),
      .d1     (d1),
      .d0     (d0)
   );

   // Present a request for one edge, then scramble inputs to prove they were latched
   task automatic start_conv(input logic [W-1:0] v, input logic en, input logic [2:0] pos);
      @(negedge clk);
      value  = v;
      dp_en  = en;
      dp_pos = pos;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      value  = ~v;
      dp_en  = ~en;
      dp_pos = 3'd1;
   endtask

   // Count edges until done (bounded), counting busy samples, then step one idle cycle
   task automatic wait_done(output int cycles, output int busy_n, output bit ok, output logic done_again);
      cycles = 0;
      busy_n = 0;
      ok     = 1'b0;
      if (busy === 1'b1) busy_n++;
      while (cycles < 200 && !ok) begin
         @(posedge clk);
         #1;
         cycles++;
         if (done === 1'b1) ok = 1'b1;
         else if (busy === 1'b1) busy_n++;
      end
      @(posedge clk);
      #1;
      done_again = done;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; value = '0; dp_en = 1'b0; dp_pos = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (disp !== ALL_BLANK) begin miscompares++; $display("FAIL reset_digits: got %h expected %h", disp, ALL_BLANK); end
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_zero();
      int cyc; int bn; bit ok; logic da;
      start_conv(24'd0, 1'b0, 3'd0);
      wait_done(cyc, bn, ok, da);
      vectors++;
      if (!ok || cyc != W + 1) begin miscompares++; $display("FAIL zero_latency: got %0d edges (ok=%b) expected %0d", cyc, ok, W + 1); end
      vectors++;
      if (disp !== {{7{7'h40}}, 7'h00}) begin miscompares++; $display("FAIL zero_digits: got %h expected %h", disp, {{7{7'h40}}, 7'h00}); end
      vectors++;
      if (da !== 1'b0) begin miscompares++; $display("FAIL zero_done_pulse: got done=%b expected 0", da); end
   endtask

   task automatic test_1234();
      int cyc; int bn; bit ok; logic da;
      start_conv(24'd1234, 1'b0, 3'd0);
      wait_done(cyc, bn, ok, da);
      vectors++;
      if (disp !== {{4{7'h40}}, 7'h01, 7'h02, 7'h03, 7'h04}) begin miscompares++; $display("FAIL d1234_digits: got %h expected %h", disp, {{4{7'h40}}, 7'h01, 7'h02, 7'h03, 7'h04}); end
      vectors++;
      if (!ok || bn != W + 1) begin miscompares++; $display("FAIL d1234_busy_cycles: got %0d expected %0d", bn, W + 1); end
   endtask

   task automatic test_min();
      int cyc; int bn; bit ok; logic da;
      start_conv(24'h800000, 1'b0, 3'd0);
      wait_done(cyc, bn, ok, da);
      vectors++;
      if (disp !== {7'h10, 7'h08, 7'h03, 7'h08, 7'h08, 7'h06, 7'h00, 7'h08}) begin miscompares++; $display("FAIL min_digits: got %h expected %h", disp, {7'h10, 7'h08, 7'h03, 7'h08, 7'h08, 7'h06, 7'h00, 7'h08}); end
   endtask

   task automatic test_neg_dp();
      int cyc; int bn; bit ok; logic da;
      start_conv(24'hFFFFFB, 1'b1, 3'd2);
      wait_done(cyc, bn, ok, da);
      vectors++;
      if (disp !== {{4{7'h40}}, 7'h10, 7'h20, 7'h00, 7'h05}) begin miscompares++; $display("FAIL neg_dp_digits: got %h expected %h", disp, {{4{7'h40}}, 7'h10, 7'h20, 7'h00, 7'h05}); end
   endtask

   task automatic test_dp_clamp();
      int cyc; int bn; bit ok; logic da;
      start_conv(24'd7, 1'b1, 3'd7);
      wait_done(cyc, bn, ok, da);
      vectors++;
      if (disp !== {7'h40, 7'h20, {5{7'h00}}, 7'h07}) begin miscompares++; $display("FAIL dp_clamp_digits: got %h expected %h", disp, {7'h40, 7'h20, {5{7'h00}}, 7'h07}); end
   endtask

   task automatic test_ignore_start();
      int cyc; int bn; bit ok; logic da;
      start_conv(24'd99, 1'b0, 3'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      value = 24'd555; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      vectors++;
      if (disp !== {7'h40, 7'h20, {5{7'h00}}, 7'h07}) begin miscompares++; $display("FAIL hold_digits: got %h expected %h", disp, {7'h40, 7'h20, {5{7'h00}}, 7'h07}); end
      wait_done(cyc, bn, ok, da);
      vectors++;
      if (!ok || cyc != W - 2) begin miscompares++; $display("FAIL ignore_latency: got %0d edges (ok=%b) expected %0d", cyc, ok, W - 2); end
      vectors++;
      if (disp !== {{6{7'h40}}, 7'h09, 7'h09}) begin miscompares++; $display("FAIL ignore_digits: got %h expected %h", disp, {{6{7'h40}}, 7'h09, 7'h09}); end
      vectors++;
      if (da !== 1'b0) begin miscompares++; $display("FAIL ignore_single_done: got done=%b expected 0", da); end
   endtask

   task automatic test_back_to_back();
      int cyc; int bn; bit ok; logic da;
      start_conv(24'd11, 1'b0, 3'd0);
      repeat (W) @(posedge clk);
      #1;
      value = 24'd22; dp_en = 1'b0; dp_pos = 3'd0; start = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (done !== 1'b1 || disp !== {{6{7'h40}}, 7'h01, 7'h01}) begin miscompares++; $display("FAIL b2b_first: got done=%b %h expected 1 %h", done, disp, {{6{7'h40}}, 7'h01, 7'h01}); end
      @(posedge clk);
      #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL b2b_done_ignored: got done=%b busy=%b expected 0 0", done, busy); end
      @(posedge clk);
      #1;
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
      wait_done(cyc, bn, ok, da);
      vectors++;
      if (!ok || cyc != W + 1 || disp !== {{6{7'h40}}, 7'h02, 7'h02}) begin miscompares++; $display("FAIL b2b_second: got %0d edges %h expected %0d %h", cyc, disp, W + 1, {{6{7'h40}}, 7'h02, 7'h02}); end
   endtask

   task automatic test_abort();
      int cyc; int bn; bit ok; logic da; int dones;
      start_conv(24'd777, 1'b0, 3'd0);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      vectors++;
      if (disp !== ALL_BLANK || busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL abort_immediate: got %h busy=%b done=%b expected %h 0 0", disp, busy, done, ALL_BLANK); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < W + 5; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) dones++;
      end
      vectors++;
      if (dones != 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones); end
      start_conv(24'd42, 1'b0, 3'd0);
      wait_done(cyc, bn, ok, da);
      vectors++;
      if (!ok || disp !== {{6{7'h40}}, 7'h04, 7'h02}) begin miscompares++; $display("FAIL abort_restart: got %h (ok=%b) expected %h", disp, ok, {{6{7'h40}}, 7'h04, 7'h02}); end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_1234();
      test_min();
      test_neg_dp();
      test_dp_clamp();
      test_ignore_start();
      test_back_to_back();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
